dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL be the word-address width of the external data RAM (1024 words).
REQ-002 Parameter TIMEOUT, default 16, SHALL be the maximum number of cycles spent waiting for mem_ack.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 MemRead  input  1  SHALL be the load request from the control unit.
REQ-006 MemWrite  input  1  SHALL be the store request from the control unit.
REQ-007 ALUResult  input  32  SHALL be the byte address from the datapath ALU.
REQ-008 WriteData  input  32  SHALL be the store data from the register file.
REQ-009 ReadData  output  32  SHALL be the load data returned to the datapath result mux.
REQ-010 Stall  output  1  SHALL hold the PC register and block register-file writes while high.
REQ-011 MemFault  output  1  SHALL be the sticky access-fault flag.
REQ-012 mem_req  output  1  SHALL be the RAM request strobe.
REQ-013 mem_we  output  1  SHALL be the RAM write enable, valid with mem_req.
REQ-014 mem_addr  output  ADDR_W  SHALL be the RAM word address, ALUResult[ADDR_W+1:2].
REQ-015 mem_wdata  output  32  SHALL be the RAM write data.
REQ-016 mem_rdata  input  32  SHALL be the RAM read data, valid when mem_ack is high.
REQ-017 mem_ack  input  1  SHALL be the one-cycle RAM completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE.
REQ-019 IDLE: when MemRead or MemWrite is high and the access is legal, Stall SHALL be asserted combinationally, address/data/we SHALL be registered, and the next state SHALL be REQ.
REQ-020 Access SHALL be illegal if ALUResult[1:0] != 0 or ALUResult[31:ADDR_W+2] != 0; illegal access -> MemFault set, no mem_req, ReadData = 32'h0, Stall low, remain IDLE.
REQ-021 MemRead and MemWrite both high SHALL be treated as a write.
REQ-022 REQ: mem_req SHALL be high, mem_addr/mem_wdata/mem_we SHALL be stable from registers, Stall SHALL be high.
REQ-023 REQ with mem_ack high: a read SHALL capture mem_rdata into ReadData; next state DONE.
REQ-024 REQ: wait counter SHALL increment each cycle without mem_ack; reaching TIMEOUT -> MemFault set, ReadData = 32'h0, next state DONE.
REQ-025 DONE: Stall SHALL be low and ReadData held; next state SHALL be IDLE unconditionally, so a held request does not re-trigger.
REQ-026 Minimum latency SHALL be 3 cycles (IDLE, REQ with immediate ack, DONE); each extra ack wait adds one cycle.
REQ-027 mem_ack outside REQ SHALL be ignored.
REQ-028 MemFault SHALL stay set until reset.
REQ-029 Without MemRead/MemWrite, ReadData SHALL hold its last value and Stall SHALL be low.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, wait counter 0, ReadData 0, MemFault 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, Stall 0.
REQ-031 Reset during REQ SHALL abandon the access; mem_req SHALL drop in the same cycle.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the state enum, default ADDR_W, default TIMEOUT and the fault read value 32'h0.
REQ-033 Wait counter SHALL be a sub-module wait_counter (clear, enable, terminal-count output).

Verification
REQ-034 Load 0x00000010, mem_rdata 0xCAFEF00D, ack in first REQ cycle -> mem_addr 4, Stall high 2 cycles, ReadData 0xCAFEF00D in DONE.
REQ-035 Store 0x12345678 to 0x00000020, ack after 3 wait cycles -> mem_we 1, mem_addr 8, mem_wdata 0x12345678, Stall high 5 cycles.
REQ-036 Load from 0x00000013 -> no mem_req, MemFault 1, ReadData 0, Stall low.
REQ-037 Load 0x00000004, no ack -> MemFault 1 after 16 REQ cycles, ReadData 0, then IDLE.
REQ-038 Reset asserted during REQ -> mem_req, Stall and state cleared immediately; stray mem_ack afterwards ignored.
REQ-039 MemRead held high across DONE -> exactly one mem_req burst per request.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
// Holds the FSM state encoding, default geometry/timeout and the fault read value.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam logic [31:0] FAULT_RDATA = 32'h0;

    // Word aligned and inside the RAM window.
    function automatic logic is_legal(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_ctrl_wait_counter.sv
// Ack-wait counter: counts REQ cycles without an ack, flags the last allowed one.
// tc is high while the count sits at TIMEOUT-1, i.e. during the final wait cycle.
module wait_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns single-cycle load/store requests into a RAM
// req/ack handshake, stalling the core until the access completes or times out.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite; legal access latched, illegal flags fault
// REQ   | mem_req held from latched address/data until ack or timeout
// DONE  | stall released, result visible; always returns to IDLE
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              MemFault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              wait_tc;
    logic              in_req;

    assign in_req    = (state_q == ST_REQ);
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ReadData  = rdata_q;
    assign MemFault  = fault_q;

    wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_req),
        .enable (in_req && !mem_ack),
        .tc     (wait_tc)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        Stall   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    if (is_legal(ALUResult, ADDR_W)) begin
                        Stall   = 1'b1;
                        addr_d  = ALUResult[ADDR_W+1:2];
                        wdata_d = WriteData;
                        we_d    = MemWrite;  // read+write together is a store
                        state_d = ST_REQ;
                    end else begin
                        fault_d = 1'b1;
                        rdata_d = FAULT_RDATA;
                    end
                end
            end
            ST_REQ: begin
                Stall = 1'b1;
                // An ack on the last allowed cycle still completes normally.
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (wait_tc) begin
                    fault_d = 1'b1;
                    rdata_d = FAULT_RDATA;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus queues expected RAM requests and
// completions, a negedge monitor pops and compares them as the DUT produces them.
module tb_dmem_ctrl;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              MemRead, MemWrite;
    logic [31:0]       ALUResult, WriteData, ReadData;
    logic              Stall, MemFault, mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [31:0]       wdata;
    } exp_req_t;

    typedef struct {
        int          stall_len;
        logic [31:0] rdata;
        logic        fault;
    } exp_done_t;

    exp_req_t  req_q[$];
    exp_done_t done_q[$];

    dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemFault  (MemFault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a rising mem_req is a request event, a falling Stall run is a completion.
    logic req_prev = 1'b0;
    int   run      = 0;
    always @(negedge clk) begin
        if (reset) begin
            req_prev = 1'b0;
            run      = 0;
        end else begin
            if (mem_req && !req_prev) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    exp_req_t e;
                    e = req_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            req_prev = mem_req;
            if (Stall) begin
                run++;
            end else if (run > 0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_done_t d;
                    d = done_q.pop_front();
                    chk("stall_cycles", 32'(run), 32'(d.stall_len));
                    chk("ReadData", ReadData, d.rdata);
                    chk("MemFault", 32'(MemFault), 32'(d.fault));
                end
                run = 0;
            end
        end
    end

    // ack_dly < 0 means never ack; the request is held through DONE on purpose.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_dly, input logic [31:0] rdat,
                          input logic [31:0] exp_rdata, input logic exp_fault);
        exp_req_t  r;
        exp_done_t d;
        r.addr  = addr[ADDR_W+1:2];
        r.we    = wr;
        r.wdata = wd;
        d.stall_len = (ack_dly < 0) ? 1 + int'(TIMEOUT) : ack_dly + 2;
        d.rdata     = exp_rdata;
        d.fault     = exp_fault;
        req_q.push_back(r);
        done_q.push_back(d);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wd;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            if (ack_dly >= 0 && i == ack_dly) begin
                mem_ack = 1'b1; mem_rdata = rdat;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (ack_dly >= 0 && i == ack_dly) break;
            if (ack_dly < 0 && i == int'(TIMEOUT) - 1) break;
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic illegal_load(input logic [31:0] addr);
        @(posedge clk); #1;
        MemRead = 1'b1; ALUResult = addr;
        @(negedge clk);
        chk("illegal_stall", 32'(Stall), 32'd0);
        chk("illegal_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        chk("illegal_fault", 32'(MemFault), 32'd1);
        chk("illegal_rdata", ReadData, 32'h0);
        MemRead = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        chk("rst_ReadData", ReadData, 32'h0);
        chk("rst_Stall", 32'(Stall), 32'd0);
        chk("rst_MemFault", 32'(MemFault), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'h0, 32'hCAFE_F00D, 1'b0);
        access(1'b1, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1, 32'h5555_5555, 32'hCAFE_F00D, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0, 32'h1122_3344, 32'h1122_3344, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0004, 32'h0, -1, 32'h0, 32'h0, 1'b1);

        @(posedge clk); #2 reset = 1'b1;
        #2 reset = 1'b0;
        access(1'b1, 1'b0, 32'h0000_000C, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        illegal_load(32'h0000_0013);
        illegal_load(32'h0000_1000);

        // Reset in the middle of REQ abandons the access immediately.
        @(posedge clk); #1;
        MemRead = 1'b1; ALUResult = 32'h0000_0040;
        @(posedge clk); #1;
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        #1 reset = 1'b1; MemRead = 1'b0;
        #1;
        chk("midreq_mem_req", 32'(mem_req), 32'd0);
        chk("midreq_Stall", 32'(Stall), 32'd0);
        chk("midreq_MemFault", 32'(MemFault), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Stray ack while idle must do nothing.
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stray_mem_req", 32'(mem_req), 32'd0);
        chk("stray_Stall", 32'(Stall), 32'd0);
        @(posedge clk); #1 mem_ack = 1'b0;
        chk("stray_ReadData", ReadData, 32'h0);

        access(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pending_requests", 32'(req_q.size()), 32'd0);
        chk("pending_completions", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
